// File: rtl/uart_login_pkg.sv
// Shared types and constants for the UART login checker.
// Holds the receiver/login state enums and a credential character helper.
package uart_login_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;
  typedef enum logic [1:0] {USER, PASS, DONE} login_state_e;

  localparam int CRED_LEN  = 4;
  localparam int TOTAL_LEN = 8;

  // Credentials hold their first character in [31:24].
  function automatic logic [7:0] cred_char(input logic [31:0] cred, input logic [1:0] pos);
    logic [31:0] w_shifted;
    w_shifted = cred >> {~pos, 3'b000};
    return w_shifted[7:0];
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer and a mid-bit sampling down-counter.
// A valid stop bit publishes the byte and pulses data_valid for one cycle.
module uart_rx
  import uart_login_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid
);

  // state | meaning
  // IDLE  | line idle, waiting for a low level
  // START | timing to mid start bit, rejects glitches
  // DATA  | sampling 8 data bits LSB first
  // STOP  | sampling the stop bit

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             r_rx_meta;
  logic             r_rx_sync;
  rx_state_e        r_state;
  rx_state_e        w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             w_tc;

  assign w_tc       = (r_cnt == '0);
  assign data_out   = r_data;
  assign data_valid = r_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_state   <= IDLE;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_state   <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!r_rx_sync) w_next = START;
      START:   if (w_tc) w_next = r_rx_sync ? IDLE : DATA;
      DATA:    if (w_tc && (r_bit_idx == 3'd7)) w_next = STOP;
      STOP:    if (w_tc) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= HALF_LOAD;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_data    <= 8'd0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: r_cnt <= HALF_LOAD;
        START: begin
          if (w_tc) begin
            r_cnt     <= FULL_LOAD;
            r_bit_idx <= 3'd0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DATA: begin
          if (w_tc) begin
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            r_cnt     <= FULL_LOAD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        STOP: begin
          if (w_tc) begin
            // A low stop bit is a framing error: drop the byte silently.
            if (r_rx_sync) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
            end
            r_cnt <= HALF_LOAD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_cnt <= HALF_LOAD;
      endcase
    end
  end

endmodule

// File: rtl/uart_login_system.sv
// UART-fed credential checker: compares an 8-byte username+password stream
// against fixed credentials and raises a sticky success or fail flag.
module uart_login_system
  import uart_login_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [31:0] USERNAME     = "user",
  parameter logic [31:0] PASSWORD     = "pass"
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       login_success,
  output logic       login_fail
);

  // state | meaning
  // USER  | receiving username characters, idx 0..3
  // PASS  | receiving password characters, idx 4..7
  // DONE  | result held; next byte starts a fresh attempt

  localparam logic [2:0] USER_LAST = 3'(CRED_LEN - 1);
  localparam logic [2:0] LAST_IDX  = 3'(TOTAL_LEN - 1);

  logic [7:0]   w_byte;
  logic         w_valid;
  login_state_e r_state;
  login_state_e w_next;
  logic [2:0]   r_idx;
  logic         r_mismatch;
  logic         r_success;
  logic         r_fail;
  logic [7:0]   w_exp;
  logic         w_bad;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (w_byte),
    .data_valid(w_valid)
  );

  assign rx_data       = w_byte;
  assign rx_data_valid = w_valid;
  assign login_success = r_success;
  assign login_fail    = r_fail;

  // idx is 0 in DONE, so the restarting byte is checked as username char 0.
  assign w_exp = (r_idx > USER_LAST) ? cred_char(PASSWORD, r_idx[1:0])
                                     : cred_char(USERNAME, r_idx[1:0]);
  assign w_bad = (w_byte != w_exp);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= USER;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_valid) begin
      case (r_state)
        USER:    if (r_idx == USER_LAST) w_next = PASS;
        PASS:    if (r_idx == LAST_IDX) w_next = DONE;
        DONE:    w_next = USER;
        default: w_next = USER;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx      <= 3'd0;
      r_mismatch <= 1'b0;
      r_success  <= 1'b0;
      r_fail     <= 1'b0;
    end else if (w_valid) begin
      if (r_state == DONE) begin
        r_success  <= 1'b0;
        r_fail     <= 1'b0;
        r_mismatch <= w_bad;
        r_idx      <= 3'd1;
      end else if (r_idx == LAST_IDX) begin
        r_success  <= ~r_mismatch & ~w_bad;
        r_fail     <= r_mismatch | w_bad;
        r_mismatch <= 1'b0;
        r_idx      <= 3'd0;
      end else begin
        r_mismatch <= r_mismatch | w_bad;
        r_idx      <= r_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_login_system.sv
// Randomized self-checking bench for uart_login_system against an attempt-level model.
module tb_uart_login_system;

  localparam int CPB = 10;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       login_success;
  logic       login_fail;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] q_got[$];
  logic [7:0] cred[8];
  logic [7:0] m_att[$];
  bit         m_done;
  bit         m_succ;
  bit         m_fail;

  uart_login_system #(
    .CLKS_PER_BIT(CPB),
    .USERNAME    (32'h75736572),
    .PASSWORD    (32'h70617373)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_data_valid(rx_data_valid),
    .login_success(login_success),
    .login_fail   (login_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rst === 1'b1 && rx_data_valid === 1'b1) q_got.push_back(rx_data);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_att.delete();
    m_done = 1'b0;
    m_succ = 1'b0;
    m_fail = 1'b0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    bit ok;
    if (m_done) begin
      m_done = 1'b0;
      m_succ = 1'b0;
      m_fail = 1'b0;
    end
    m_att.push_back(b);
    if (m_att.size() == 8) begin
      ok = 1'b1;
      foreach (m_att[i]) if (m_att[i] != cred[i]) ok = 1'b0;
      m_succ = ok;
      m_fail = !ok;
      m_done = 1'b1;
      m_att.delete();
    end
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input string tag);
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (3 + $urandom_range(0, 8)) @(negedge clk);
    if (!stop_ok) repeat (10) @(negedge clk);
    if (stop_ok) begin
      check({tag, " pulses"}, q_got.size(), 1);
      if (q_got.size() > 0) check({tag, " byte"}, q_got[0], b);
      model_byte(b);
    end else begin
      check({tag, " nopulse"}, q_got.size(), 0);
    end
    q_got.delete();
    check({tag, " success"}, login_success, m_succ);
    check({tag, " fail"}, login_fail, m_fail);
  endtask

  task automatic send_word(input logic [63:0] w, input string tag);
    for (int i = 0; i < 8; i++) send_frame(w[63-8*i -: 8], 1'b1, tag);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] w;
    logic [63:0] seq6;
    int          pos;
    cred = '{8'h75, 8'h73, 8'h65, 8'h72, 8'h70, 8'h61, 8'h73, 8'h73};
    model_reset();
    rx  = 1'b1;
    rst = 1'b1;
    #2 rst = 1'b0;
    #100;
    check("reset rx_data", rx_data, 0);
    check("reset valid", rx_data_valid, 0);
    check("reset success", login_success, 0);
    check("reset fail", login_fail, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    send_word("userpass", "good");
    repeat (100) @(negedge clk);
    check("good held success", login_success, 1);
    check("good held fail", login_fail, 0);

    send_frame("x", 1'b1, "restart x");
    for (int i = 0; i < 7; i++) send_frame(8'($urandom), 1'b1, "fill");

    send_word("userpasx", "bad pass");
    check("bad pass fail", login_fail, 1);

    seq6 = {16'h0, "serass"};
    for (int i = 0; i < 6; i++) send_frame(seq6[47-8*i -: 8], 1'b1, "partial");
    repeat (200) @(negedge clk);
    check("partial success", login_success, 0);
    check("partial fail", login_fail, 0);

    send_frame(8'h41, 1'b0, "framing");
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch nopulse", q_got.size(), 0);
    q_got.delete();
    send_frame(8'h73, 1'b1, "after err 7");
    send_frame(8'h73, 1'b1, "after err 8");

    for (int a = 0; a < 20; a++) begin
      case ($urandom_range(0, 2))
        0: w = "userpass";
        1: begin
          w   = "userpass";
          pos = $urandom_range(0, 7);
          w[8*pos +: 8] = w[8*pos +: 8] ^ 8'($urandom_range(1, 255));
        end
        default: w = {$urandom, $urandom};
      endcase
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 7) == 0) send_frame(8'($urandom), 1'b0, "rand err");
        send_frame(w[63-8*i -: 8], 1'b1, "rand");
      end
    end

    send_word("userpass", "pre reset");
    rx = 1'b0;
    repeat (35) @(negedge clk);
    rst = 1'b0;
    #2;
    check("midrst rx_data", rx_data, 0);
    check("midrst valid", rx_data_valid, 0);
    check("midrst success", login_success, 0);
    check("midrst fail", login_fail, 0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    model_reset();
    q_got.delete();
    repeat (5) @(negedge clk);
    send_word("userpass", "post reset");
    check("post reset success", login_success, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
